usbfs_rx_txn_decoder: RTL and testbench



---
 rtl/usbfs_rx_txn_decoder_pkg.sv | 35 +++
 rtl/usbfs_rx_txn_decoder_data_toggle.sv | 46 ++++
 rtl/usbfs_rx_txn_decoder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_usbfs_rx_txn_decoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usbfs_rx_txn_decoder_pkg.sv
// Shared constants for the USB full-speed receive transaction decoder:
// PID values, PID groups, transaction-type encoding and FSM state encoding.
package usbfs_rx_txn_decoder_pkg;

  // PID values (4-bit PID field, check nibble already stripped)
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  // PID group is encoded in the two LSBs
  localparam logic [1:0] PID_GRP_TOKEN = 2'b01;
  localparam logic [1:0] PID_GRP_DATA  = 2'b11;

  // Transaction type carried on o_txn_isSetup
  localparam logic TXN_SETUP = 1'b1;
  localparam logic TXN_OUT   = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_WAIT_DATA = 1'b1
  } rx_state_e;

  function automatic logic is_token_pid(input logic [3:0] pid);
    return pid[1:0] == PID_GRP_TOKEN;
  endfunction

  // DATA0 / DATA1 only (DATA2 and MDATA are high-speed PIDs)
  function automatic logic is_data01_pid(input logic [3:0] pid);
    return (pid[1:0] == PID_GRP_DATA) && !pid[2];
  endfunction

endpackage

// File: rtl/usbfs_rx_txn_decoder_data_toggle.sv
// usbfs_data_toggle: per-endpoint DATA0/DATA1 sequence bits.
// Ports: i_clk_48MHz/i_rst clock and sync reset; i_endp selects the endpoint
// for both read and update; i_set_data1 forces DATA1 (after SETUP);
// i_flip toggles (accepted OUT); o_expect_data1_c is the combinational
// expected toggle of i_endp (1 = DATA1).
module usbfs_data_toggle
  import usbfs_rx_txn_decoder_pkg::*;
#(
  parameter int unsigned N_ENDP = 2
) (
  input  logic       i_clk_48MHz,
  input  logic       i_rst,
  input  logic [3:0] i_endp,
  input  logic       i_set_data1,
  input  logic       i_flip,
  output logic       o_expect_data1_c
);

  logic [N_ENDP-1:0] toggle_q;
  logic [N_ENDP-1:0] toggle_d;

  // Read and update the selected endpoint; SETUP wins over flip
  always_comb begin
    toggle_d         = toggle_q;
    o_expect_data1_c = 1'b0;
    for (int unsigned e = 0; e < N_ENDP; e++) begin
      if (i_endp == 4'(e)) begin
        o_expect_data1_c = toggle_q[e];
        if (i_set_data1) begin
          toggle_d[e] = 1'b1;
        end else if (i_flip) begin
          toggle_d[e] = ~toggle_q[e];
        end
      end
    end
  end

  always_ff @(posedge i_clk_48MHz) begin
    if (i_rst) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

endmodule

// File: rtl/usbfs_rx_txn_decoder.sv
// usbfs_rx_txn_decoder: turns received full-speed packets into transactions.
// Filters tokens by address/endpoint, pairs SETUP/OUT with the following
// DATA packet, checks DATA0/DATA1 sequencing and buffers one transaction.
// Inputs : receiver packet outputs (i_eop, i_pid, flags, i_addr, i_endp,
//          i_lastData, i_lastData_nBytes), i_devAddr, i_txn_ready.
// Outputs: o_txn_* buffered transaction (valid/ready), o_hs_req/o_hs_ack
//          handshake request, o_in_req/o_in_endp, o_sof/o_frameNumber,
//          o_overrun. All outputs registered.
// Optional: USBFS_RX_TXN_STATS_EN adds saturating error counters
//          o_errCrc, o_errTimeout, o_errDup.
module usbfs_rx_txn_decoder
  import usbfs_rx_txn_decoder_pkg::*;
#(
  parameter int unsigned MAX_PKT      = 8,
  parameter int unsigned N_ENDP       = 2,
  parameter int unsigned DATA_TIMEOUT = 72
) (
  input  logic                          i_clk_48MHz,
  input  logic                          i_rst,
  input  logic [6:0]                    i_devAddr,
  input  logic                          i_eop,
  input  logic [3:0]                    i_pid,
  input  logic                          i_pidOkay,
  input  logic                          i_tokenOkay,
  input  logic                          i_dataOkay,
  input  logic [6:0]                    i_addr,
  input  logic [3:0]                    i_endp,
  input  logic [8*MAX_PKT-1:0]          i_lastData,
  input  logic [$clog2(MAX_PKT):0]      i_lastData_nBytes,
  output logic                          o_txn_valid,
  input  logic                          i_txn_ready,
  output logic                          o_txn_isSetup,
  output logic [3:0]                    o_txn_endp,
  output logic [8*MAX_PKT-1:0]          o_txn_data,
  output logic [$clog2(MAX_PKT):0]      o_txn_nBytes,
  output logic                          o_hs_req,
  output logic                          o_hs_ack,
  output logic                          o_in_req,
  output logic [3:0]                    o_in_endp,
  output logic                          o_sof,
  output logic [10:0]                   o_frameNumber,
`ifdef USBFS_RX_TXN_STATS_EN
  output logic [7:0]                    o_errCrc,
  output logic [7:0]                    o_errTimeout,
  output logic [7:0]                    o_errDup,
`endif
  output logic                          o_overrun
);

  localparam int unsigned NB_W  = $clog2(MAX_PKT) + 1;
  localparam int unsigned DW    = 8 * MAX_PKT;
  localparam int unsigned TMR_W = $clog2(DATA_TIMEOUT + 1);

  rx_state_e         state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              pend_setup_q, pend_setup_d;
  logic [3:0]        pend_endp_q, pend_endp_d;
  logic              hs_req_q, hs_req_d, hs_ack_q, hs_ack_d;
  logic              in_req_q, in_req_d, sof_q, sof_d, overrun_q, overrun_d;
  logic [3:0]        in_endp_q, in_endp_d;
  logic [10:0]       frame_q, frame_d;
  logic              txn_valid_q, txn_valid_d, txn_setup_q, txn_setup_d;
  logic [3:0]        txn_endp_q, txn_endp_d;
  logic [DW-1:0]     txn_data_q, txn_data_d;
  logic [NB_W-1:0]   txn_nbytes_q, txn_nbytes_d;

  logic tok_match, tok_start, data_eop, eval_tok, data_good, timeout;
  logic buf_busy, pid_is_d1, expect_d1;
  logic hs_fire, hs_ack, load, ovr, set_d1, flip;

  usbfs_data_toggle #(.N_ENDP(N_ENDP)) u_toggle (
    .i_clk_48MHz      (i_clk_48MHz),
    .i_rst            (i_rst),
    .i_endp           (pend_endp_q),
    .i_set_data1      (set_d1),
    .i_flip           (flip),
    .o_expect_data1_c (expect_d1)
  );

  // Packet classification; a non-data PID in WAIT_DATA is treated as a token
  always_comb begin
    tok_match = is_token_pid(i_pid) && i_pidOkay && i_tokenOkay &&
                (i_addr == i_devAddr) && ({1'b0, i_endp} < 5'(N_ENDP));
    data_eop  = i_eop && (state_q == ST_WAIT_DATA) && is_data01_pid(i_pid);
    eval_tok  = i_eop && !data_eop;
    tok_start = eval_tok && tok_match && ((i_pid == PID_SETUP) || (i_pid == PID_OUT));
    data_good = i_pidOkay && i_dataOkay && (i_lastData_nBytes <= NB_W'(MAX_PKT));
    timeout   = (state_q == ST_WAIT_DATA) && !i_eop && (timer_q == TMR_W'(DATA_TIMEOUT - 1));
    buf_busy  = txn_valid_q && !i_txn_ready;
    pid_is_d1 = (i_pid == PID_DATA1);
  end

  // Data-stage evaluation: handshake, buffer load and toggle update
  always_comb begin
    hs_fire = 1'b0;
    hs_ack  = 1'b0;
    load    = 1'b0;
    ovr     = 1'b0;
    set_d1  = 1'b0;
    flip    = 1'b0;
    if (data_eop && data_good) begin
      if (pend_setup_q == TXN_SETUP) begin
        if (!pid_is_d1) begin
          hs_fire = 1'b1;
          hs_ack  = 1'b1;
          load    = 1'b1;
          set_d1  = 1'b1;
          ovr     = buf_busy;
        end
      end else if (pid_is_d1 != expect_d1) begin
        // retransmission of data already accepted
        hs_fire = 1'b1;
        hs_ack  = 1'b1;
      end else if (buf_busy) begin
        hs_fire = 1'b1;
      end else begin
        hs_fire = 1'b1;
        hs_ack  = 1'b1;
        load    = 1'b1;
        flip    = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tok_start) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (tok_start) begin
          state_d = ST_WAIT_DATA;
        end else if (i_eop || timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register next values for outputs, pending token and timer
  always_comb begin
    timer_d      = timer_q;
    pend_setup_d = pend_setup_q;
    pend_endp_d  = pend_endp_q;
    in_endp_d    = in_endp_q;
    frame_d      = frame_q;
    txn_setup_d  = txn_setup_q;
    txn_endp_d   = txn_endp_q;
    txn_data_d   = txn_data_q;
    txn_nbytes_d = txn_nbytes_q;
    txn_valid_d  = txn_valid_q && !i_txn_ready;
    hs_req_d     = hs_fire;
    hs_ack_d     = hs_ack;
    overrun_d    = ovr;
    in_req_d     = eval_tok && tok_match && (i_pid == PID_IN);
    sof_d        = eval_tok && (i_pid == PID_SOF) && i_pidOkay && i_tokenOkay;

    if (tok_start) begin
      timer_d      = '0;
      pend_setup_d = (i_pid == PID_SETUP) ? TXN_SETUP : TXN_OUT;
      pend_endp_d  = i_endp;
    end else if (state_q == ST_WAIT_DATA) begin
      timer_d = timer_q + TMR_W'(1);
    end
    if (in_req_d) in_endp_d = i_endp;
    if (sof_d)    frame_d   = {i_endp, i_addr};
    if (load) begin
      txn_valid_d  = 1'b1;
      txn_setup_d  = pend_setup_q;
      txn_endp_d   = pend_endp_q;
      txn_data_d   = i_lastData;
      txn_nbytes_d = i_lastData_nBytes;
    end
  end

  // State register
  always_ff @(posedge i_clk_48MHz) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk_48MHz) begin
    if (i_rst) begin
      timer_q      <= '0;
      pend_setup_q <= 1'b0;
      pend_endp_q  <= '0;
      hs_req_q     <= 1'b0;
      hs_ack_q     <= 1'b0;
      in_req_q     <= 1'b0;
      in_endp_q    <= '0;
      sof_q        <= 1'b0;
      frame_q      <= '0;
      overrun_q    <= 1'b0;
      txn_valid_q  <= 1'b0;
      txn_setup_q  <= 1'b0;
      txn_endp_q   <= '0;
      txn_data_q   <= '0;
      txn_nbytes_q <= '0;
    end else begin
      timer_q      <= timer_d;
      pend_setup_q <= pend_setup_d;
      pend_endp_q  <= pend_endp_d;
      hs_req_q     <= hs_req_d;
      hs_ack_q     <= hs_ack_d;
      in_req_q     <= in_req_d;
      in_endp_q    <= in_endp_d;
      sof_q        <= sof_d;
      frame_q      <= frame_d;
      overrun_q    <= overrun_d;
      txn_valid_q  <= txn_valid_d;
      txn_setup_q  <= txn_setup_d;
      txn_endp_q   <= txn_endp_d;
      txn_data_q   <= txn_data_d;
      txn_nbytes_q <= txn_nbytes_d;
    end
  end

`ifdef USBFS_RX_TXN_STATS_EN
  logic [7:0] err_crc_q, err_crc_d, err_to_q, err_to_d, err_dup_q, err_dup_d;
  logic       crc_bad;

  // Saturating error counters; a duplicate is an ACK without a load
  always_comb begin
    crc_bad   = i_eop && (!i_pidOkay || (is_token_pid(i_pid) && !i_tokenOkay) ||
                          ((i_pid[1:0] == PID_GRP_DATA) && !i_dataOkay));
    err_crc_d = err_crc_q;
    err_to_d  = err_to_q;
    err_dup_d = err_dup_q;
    if (crc_bad && (err_crc_q != 8'hFF))                 err_crc_d = err_crc_q + 8'd1;
    if (timeout && (err_to_q != 8'hFF))                  err_to_d  = err_to_q + 8'd1;
    if (hs_ack && !load && (err_dup_q != 8'hFF))         err_dup_d = err_dup_q + 8'd1;
  end

  always_ff @(posedge i_clk_48MHz) begin
    if (i_rst) begin
      err_crc_q <= '0;
      err_to_q  <= '0;
      err_dup_q <= '0;
    end else begin
      err_crc_q <= err_crc_d;
      err_to_q  <= err_to_d;
      err_dup_q <= err_dup_d;
    end
  end

  assign o_errCrc     = err_crc_q;
  assign o_errTimeout = err_to_q;
  assign o_errDup     = err_dup_q;
`endif

  assign o_txn_valid   = txn_valid_q;
  assign o_txn_isSetup = txn_setup_q;
  assign o_txn_endp    = txn_endp_q;
  assign o_txn_data    = txn_data_q;
  assign o_txn_nBytes  = txn_nbytes_q;
  assign o_hs_req      = hs_req_q;
  assign o_hs_ack      = hs_ack_q;
  assign o_in_req      = in_req_q;
  assign o_in_endp     = in_endp_q;
  assign o_sof         = sof_q;
  assign o_frameNumber = frame_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_usbfs_rx_txn_decoder.sv
// Testbench for usbfs_rx_txn_decoder: directed scenarios followed by random
// packet traffic, every cycle compared against a packet-level reference model.
module tb_usbfs_rx_txn_decoder;

  localparam int unsigned MAX_PKT      = 8;
  localparam int unsigned N_ENDP       = 2;
  localparam int unsigned DATA_TIMEOUT = 72;
  localparam logic [6:0]  DEV_ADDR     = 7'd5;

  localparam logic [3:0] P_OUT = 4'h1, P_IN = 4'h9, P_SOF = 4'h5, P_SETUP = 4'hD;
  localparam logic [3:0] P_DATA0 = 4'h3, P_DATA1 = 4'hB, P_DATA2 = 4'h7;
  localparam logic [3:0] P_ACK = 4'h2, P_NAK = 4'hA;

  typedef struct {
    logic        eop;
    logic [3:0]  pid;
    logic        pid_ok;
    logic        tok_ok;
    logic        dat_ok;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic [3:0]  nb;
  } pkt_t;

  logic        clk = 1'b0;
  logic        i_rst, i_eop, i_pidOkay, i_tokenOkay, i_dataOkay, i_txn_ready;
  logic [6:0]  i_devAddr, i_addr;
  logic [3:0]  i_pid, i_endp;
  logic [63:0] i_lastData;
  logic [3:0]  i_lastData_nBytes;
  logic        o_txn_valid, o_txn_isSetup, o_hs_req, o_hs_ack, o_in_req, o_sof, o_overrun;
  logic [3:0]  o_txn_endp, o_in_endp;
  logic [63:0] o_txn_data;
  logic [3:0]  o_txn_nBytes;
  logic [10:0] o_frameNumber;
`ifdef USBFS_RX_TXN_STATS_EN
  logic [7:0]  o_errCrc, o_errTimeout, o_errDup;
`endif

  usbfs_rx_txn_decoder #(.MAX_PKT(MAX_PKT), .N_ENDP(N_ENDP), .DATA_TIMEOUT(DATA_TIMEOUT)) dut (
    .i_clk_48MHz(clk), .i_rst(i_rst), .i_devAddr(i_devAddr), .i_eop(i_eop),
    .i_pid(i_pid), .i_pidOkay(i_pidOkay), .i_tokenOkay(i_tokenOkay),
    .i_dataOkay(i_dataOkay), .i_addr(i_addr), .i_endp(i_endp),
    .i_lastData(i_lastData), .i_lastData_nBytes(i_lastData_nBytes),
    .o_txn_valid(o_txn_valid), .i_txn_ready(i_txn_ready),
    .o_txn_isSetup(o_txn_isSetup), .o_txn_endp(o_txn_endp),
    .o_txn_data(o_txn_data), .o_txn_nBytes(o_txn_nBytes),
    .o_hs_req(o_hs_req), .o_hs_ack(o_hs_ack), .o_in_req(o_in_req),
    .o_in_endp(o_in_endp), .o_sof(o_sof), .o_frameNumber(o_frameNumber),
`ifdef USBFS_RX_TXN_STATS_EN
    .o_errCrc(o_errCrc), .o_errTimeout(o_errTimeout), .o_errDup(o_errDup),
`endif
    .o_overrun(o_overrun)
  );

  initial forever #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending token, per-endpoint toggles, one-entry buffer
  bit          m_pend, m_pend_setup;
  logic [3:0]  m_pend_endp;
  int unsigned m_tok_p;
  bit          m_tog [N_ENDP];
  bit          m_bv, m_bsetup;
  logic [3:0]  m_bendp, m_bnb;
  logic [63:0] m_bdata;
  logic [3:0]  m_in_endp;
  logic [10:0] m_frame;
  bit          e_hs, e_ack, e_in, e_sof, e_ovr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_cnt);
    end
  endtask

  // Predict the outputs visible after the posedge with index p
  task automatic model(input pkt_t k, input logic rdy, input logic rst, input int unsigned p);
    bit load, consumed, live, isdata, d1, addressed;
    int e;
    e_hs = 0; e_ack = 0; e_in = 0; e_sof = 0; e_ovr = 0;
    if (rst) begin
      m_pend = 0; m_bv = 0; m_bsetup = 0; m_bendp = '0; m_bnb = '0; m_bdata = '0;
      m_in_endp = '0; m_frame = '0;
      for (int i = 0; i < int'(N_ENDP); i++) m_tog[i] = 0;
    end else begin
      load     = 0;
      consumed = m_bv && rdy;
      if (k.eop) begin
        live   = m_pend && ((p - m_tok_p) <= DATA_TIMEOUT);
        isdata = (k.pid == P_DATA0) || (k.pid == P_DATA1);
        e      = int'(m_pend_endp);
        if (live && isdata) begin
          m_pend = 0;
          if (k.pid_ok && k.dat_ok && (int'(k.nb) <= int'(MAX_PKT))) begin
            d1 = (k.pid == P_DATA1);
            if (m_pend_setup) begin
              if (!d1) begin
                e_hs = 1; e_ack = 1; load = 1; m_tog[e] = 1; e_ovr = m_bv && !rdy;
              end
            end else if (d1 != m_tog[e]) begin
              e_hs = 1; e_ack = 1;
            end else if (m_bv && !rdy) begin
              e_hs = 1;
            end else begin
              e_hs = 1; e_ack = 1; load = 1; m_tog[e] = !m_tog[e];
            end
          end
        end else begin
          m_pend    = 0;
          addressed = k.pid_ok && k.tok_ok && (k.addr == DEV_ADDR) && (int'(k.endp) < int'(N_ENDP));
          if ((k.pid == P_SOF) && k.pid_ok && k.tok_ok) begin
            e_sof = 1; m_frame = {k.endp, k.addr};
          end else if (addressed && (k.pid == P_IN)) begin
            e_in = 1; m_in_endp = k.endp;
          end else if (addressed && ((k.pid == P_SETUP) || (k.pid == P_OUT))) begin
            m_pend = 1; m_pend_setup = (k.pid == P_SETUP); m_pend_endp = k.endp; m_tok_p = p;
          end
        end
      end
      if (load) begin
        m_bv = 1; m_bsetup = m_pend_setup; m_bendp = m_pend_endp; m_bdata = k.data; m_bnb = k.nb;
      end else if (consumed) begin
        m_bv = 0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, compare at the falling edge
  task automatic step(input pkt_t k, input logic rdy, input logic rst);
    int unsigned p;
    i_eop = k.eop; i_pid = k.pid; i_pidOkay = k.pid_ok; i_tokenOkay = k.tok_ok;
    i_dataOkay = k.dat_ok; i_addr = k.addr; i_endp = k.endp; i_lastData = k.data;
    i_lastData_nBytes = k.nb; i_txn_ready = rdy; i_rst = rst;
    p = cyc_cnt + 1;
    model(k, rdy, rst, p);
    @(negedge clk);
    check("hs_req", 64'(o_hs_req), 64'(e_hs));
    if (e_hs) check("hs_ack", 64'(o_hs_ack), 64'(e_ack));
    check("in_req", 64'(o_in_req), 64'(e_in));
    if (e_in) check("in_endp", 64'(o_in_endp), 64'(m_in_endp));
    check("sof", 64'(o_sof), 64'(e_sof));
    if (e_sof) check("frame", 64'(o_frameNumber), 64'(m_frame));
    check("overrun", 64'(o_overrun), 64'(e_ovr));
    check("txn_valid", 64'(o_txn_valid), 64'(m_bv));
    if (m_bv) begin
      check("txn_isSetup", 64'(o_txn_isSetup), 64'(m_bsetup));
      check("txn_endp", 64'(o_txn_endp), 64'(m_bendp));
      check("txn_data", o_txn_data, m_bdata);
      check("txn_nBytes", 64'(o_txn_nBytes), 64'(m_bnb));
    end
  endtask

  function automatic pkt_t nop();
    pkt_t k;
    k = '{eop: 0, pid: 4'h0, pid_ok: 1, tok_ok: 1, dat_ok: 1, addr: 7'h0, endp: 4'h0, data: 64'h0, nb: 4'h0};
    return k;
  endfunction

  function automatic pkt_t tok(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] e);
    pkt_t k;
    k = nop();
    k.eop = 1; k.pid = pid; k.addr = a; k.endp = e;
    return k;
  endfunction

  function automatic pkt_t dat(input logic [3:0] pid, input logic [63:0] d, input logic [3:0] nb);
    pkt_t k;
    k = nop();
    k.eop = 1; k.pid = pid; k.data = d; k.nb = nb;
    return k;
  endfunction

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(nop(), rdy, 1'b0);
  endtask

  initial begin
    pkt_t k;
    int   sel;
    i_devAddr = DEV_ADDR;

    // Reset: all outputs zero
    step(nop(), 1'b0, 1'b1);
    step(nop(), 1'b0, 1'b1);
    check("rst_nBytes", 64'(o_txn_nBytes), 64'd0);
    check("rst_frame", 64'(o_frameNumber), 64'd0);
    check("rst_in_endp", 64'(o_in_endp), 64'd0);
    check("rst_data", o_txn_data, 64'd0);

    // SETUP endp0 + DATA0 8 bytes
    step(tok(P_SETUP, 7'd5, 4'd0), 1'b0, 1'b0);
    idle(2, 1'b0);
    step(dat(P_DATA0, 64'h0807060504030201, 4'd8), 1'b0, 1'b0);
    check("setup_hs", {62'd0, o_hs_req, o_hs_ack}, 64'd3);
    check("setup_isSetup", 64'(o_txn_isSetup), 64'd1);
    check("setup_nBytes", 64'(o_txn_nBytes), 64'd8);
    check("setup_data", o_txn_data, 64'h0807060504030201);
    step(nop(), 1'b1, 1'b0);
    // OUT endp0 now expects DATA1
    step(tok(P_OUT, 7'd5, 4'd0), 1'b0, 1'b0);
    step(dat(P_DATA1, 64'h33, 4'd1), 1'b0, 1'b0);
    check("out_after_setup_valid", 64'(o_txn_valid), 64'd1);
    step(nop(), 1'b1, 1'b0);

    // OUT endp1 DATA0, then a duplicate DATA0
    step(tok(P_OUT, 7'd5, 4'd1), 1'b0, 1'b0);
    step(dat(P_DATA0, 64'hAABBCC, 4'd3), 1'b0, 1'b0);
    check("out1_ack", 64'(o_hs_ack), 64'd1);
    step(nop(), 1'b1, 1'b0);
    idle(1, 1'b0);
    step(tok(P_OUT, 7'd5, 4'd1), 1'b0, 1'b0);
    step(dat(P_DATA0, 64'hAABBCC, 4'd3), 1'b0, 1'b0);
    check("dup_ack", {62'd0, o_hs_req, o_hs_ack}, 64'd3);
    check("dup_no_valid", 64'(o_txn_valid), 64'd0);

    // Buffer held -> NAK, then ready during data eop -> ACK and load
    step(tok(P_OUT, 7'd5, 4'd0), 1'b0, 1'b0);
    step(dat(P_DATA0, 64'h1122, 4'd2), 1'b0, 1'b0);
    idle(2, 1'b0);
    step(tok(P_OUT, 7'd5, 4'd1), 1'b0, 1'b0);
    step(dat(P_DATA1, 64'h99, 4'd1), 1'b0, 1'b0);
    check("held_nak", {62'd0, o_hs_req, o_hs_ack}, 64'd2);
    check("held_endp", 64'(o_txn_endp), 64'd0);
    step(tok(P_OUT, 7'd5, 4'd1), 1'b0, 1'b0);
    step(dat(P_DATA1, 64'h99, 4'd1), 1'b1, 1'b0);
    check("ready_ack", 64'(o_hs_ack), 64'd1);
    check("ready_endp", 64'(o_txn_endp), 64'd1);
    step(nop(), 1'b1, 1'b0);

    // Wrong address, out-of-range endpoint, timeout, late but valid data
    step(tok(P_OUT, 7'd6, 4'd0), 1'b0, 1'b0);
    step(dat(P_DATA0, 64'h1, 4'd1), 1'b0, 1'b0);
    step(tok(P_OUT, 7'd5, 4'd2), 1'b0, 1'b0);
    step(dat(P_DATA0, 64'h1, 4'd1), 1'b0, 1'b0);
    step(tok(P_OUT, 7'd5, 4'd0), 1'b0, 1'b0);
    idle(80, 1'b0);
    step(dat(P_DATA1, 64'h2, 4'd1), 1'b0, 1'b0);
    check("timeout_no_hs", 64'(o_hs_req), 64'd0);
    step(tok(P_OUT, 7'd5, 4'd0), 1'b0, 1'b0);
    idle(68, 1'b0);
    step(dat(P_DATA1, 64'h2, 4'd1), 1'b0, 1'b0);
    check("late_data_hs", 64'(o_hs_req), 64'd1);
    step(nop(), 1'b1, 1'b0);

    // Bad CRC16 data, oversize data, then SOF 0x7FF
    step(tok(P_OUT, 7'd5, 4'd0), 1'b0, 1'b0);
    k = dat(P_DATA0, 64'h3, 4'd1); k.dat_ok = 0;
    step(k, 1'b0, 1'b0);
    step(tok(P_OUT, 7'd5, 4'd0), 1'b0, 1'b0);
    step(dat(P_DATA0, 64'h3, 4'd9), 1'b0, 1'b0);
    check("oversize_no_hs", 64'(o_hs_req), 64'd0);
    step(tok(P_SOF, 7'h7F, 4'hF), 1'b0, 1'b0);
    check("sof_pulse", 64'(o_sof), 64'd1);
    check("sof_frame", 64'(o_frameNumber), 64'h7FF);

    // IN endp1, SETUP overrun of a held buffer
    step(tok(P_IN, 7'd5, 4'd1), 1'b0, 1'b0);
    check("in_endp1", {60'd0, o_in_endp}, 64'd1);
    step(tok(P_SETUP, 7'd5, 4'd0), 1'b0, 1'b0);
    step(dat(P_DATA0, 64'h44, 4'd1), 1'b0, 1'b0);
    step(tok(P_SETUP, 7'd5, 4'd0), 1'b0, 1'b0);
    step(dat(P_DATA0, 64'h55, 4'd1), 1'b0, 1'b0);
    check("overrun_pulse", 64'(o_overrun), 64'd1);
    check("overrun_data", o_txn_data, 64'h55);

    // Reset during WAIT_DATA with a pending buffer
    step(tok(P_OUT, 7'd5, 4'd1), 1'b0, 1'b0);
    step(nop(), 1'b0, 1'b1);
    check("rst_valid", 64'(o_txn_valid), 64'd0);
    step(dat(P_DATA0, 64'h66, 4'd1), 1'b0, 1'b0);
    check("rst_wait_no_hs", 64'(o_hs_req), 64'd0);

    // Random packet traffic
    for (int i = 0; i < 500; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 3) begin
        case ($urandom_range(0, 3))
          0: k = tok(P_OUT, 7'd5, 4'($urandom_range(0, 2)));
          1: k = tok(P_SETUP, 7'd5, 4'($urandom_range(0, 2)));
          2: k = tok(P_IN, 7'd5, 4'($urandom_range(0, 2)));
          default: k = tok(P_SOF, 7'($urandom), 4'($urandom));
        endcase
        if ($urandom_range(0, 4) == 0) k.addr = 7'($urandom);
      end else if (sel <= 8) begin
        k = dat($urandom_range(0, 1) ? P_DATA1 : P_DATA0, {$urandom, $urandom},
                ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(0, 8)));
      end else begin
        case ($urandom_range(0, 2))
          0: k = tok(P_ACK, 7'd5, 4'd0);
          1: k = tok(P_NAK, 7'd5, 4'd0);
          default: k = dat(P_DATA2, {$urandom, $urandom}, 4'd2);
        endcase
      end
      k.pid_ok = ($urandom_range(0, 19) != 0);
      k.tok_ok = ($urandom_range(0, 19) != 0);
      k.dat_ok = ($urandom_range(0, 19) != 0);
      step(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
      for (int g = int'($urandom_range(0, 3)); g > 0; g--) step(nop(), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 39) == 0) idle(75, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
